// File: rtl/riot_pkg.sv
// Shared definitions for the RIOT-style RAM / I/O / timer block.
// Holds prescale encodings and divisors, address-field codes and the RAM reset image.
// No logic of its own; imported by riot_multi and riot_timer.
package riot_pkg;

    // Prescale select, written through addr[1:0] of a timer write.
    typedef enum logic [1:0] {
        PS_1    = 2'd0,
        PS_8    = 2'd1,
        PS_64   = 2'd2,
        PS_1024 = 2'd3
    } presc_e;

    // ce cycles per timer tick for each prescale setting.
    localparam int DIV_1    = 1;
    localparam int DIV_8    = 8;
    localparam int DIV_64   = 64;
    localparam int DIV_1024 = 1024;

    // Register-space decode on addr[7:6].
    localparam logic [1:0] AREA_PORT  = 2'b00;
    localparam logic [1:0] AREA_TIMER = 2'b01;
    localparam logic [1:0] AREA_EDGE  = 2'b10;
    localparam logic [1:0] AREA_NONE  = 2'b11;

    localparam int RAM_IMAGE_BYTES = 128;

    // Last prescaler count before a tick; the prescaler runs 0..div-1.
    function automatic logic [9:0] presc_last(input presc_e sel);
        logic [9:0] r;
        case (sel)
            PS_1:    r = 10'(DIV_1 - 1);
            PS_8:    r = 10'(DIV_8 - 1);
            PS_64:   r = 10'(DIV_64 - 1);
            default: r = 10'(DIV_1024 - 1);
        endcase
        return r;
    endfunction

    function automatic logic [RAM_IMAGE_BYTES-1:0][7:0] gen_ram_image();
        logic [RAM_IMAGE_BYTES-1:0][7:0] img;
        for (int i = 0; i < RAM_IMAGE_BYTES; i++) begin
            img[i] = 8'(i * 37 + 11);
        end
        return img;
    endfunction

    // RAM contents after reset when RAM_INIT = 1.
    localparam logic [RAM_IMAGE_BYTES-1:0][7:0] RAM_INIT_IMAGE = gen_ram_image();

endpackage

// File: rtl/riot_timer.sv
// One interval timer: 8-bit count, 1/8/64/1024 prescaler, reload latch, underflow flag.
// Count, flag and enable are registers; a write or read acts on the edge of its ce cycle.
// No backpressure; state only advances on ce, reset overrides ce.
// Ports: clk, reset, ce; wr/rd strobes (already qualified by ce & cs & decode);
//        cfg_* from the address lines of the access; d_in write data;
//        count, flag, irq_en registered outputs.
module riot_timer
    import riot_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       wr,
    input  logic       rd,
    input  logic       cfg_irq_en,
    input  logic       cfg_reload,
    input  presc_e     cfg_presc,
    input  logic [7:0] d_in,
    output logic [7:0] count,
    output logic       flag,
    output logic       irq_en
);

    logic [7:0] latch;
    logic [9:0] presc_cnt;
    presc_e     presc_sel;
    logic       reload;
    // After a one-shot underflow the count runs down at ce rate and parks at 0x00.
    logic       fast;

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 8'h00;
            latch     <= 8'h00;
            presc_cnt <= '0;
            presc_sel <= PS_1024;
            reload    <= 1'b0;
            fast      <= 1'b1;
            flag      <= 1'b0;
            irq_en    <= 1'b0;
        end else if (ce) begin
            if (wr) begin
                // A write beats a coincident underflow: new count, flag cleared.
                count     <= d_in;
                latch     <= d_in;
                presc_cnt <= '0;
                presc_sel <= cfg_presc;
                reload    <= cfg_reload;
                irq_en    <= cfg_irq_en;
                fast      <= 1'b0;
                flag      <= 1'b0;
            end else begin
                if (rd) begin
                    irq_en <= cfg_irq_en;
                    flag   <= 1'b0;
                end
                if (fast) begin
                    if (count != 8'h00) begin
                        count <= count - 8'h01;
                    end
                end else if (presc_cnt == presc_last(presc_sel)) begin
                    presc_cnt <= '0;
                    if (count == 8'h00) begin
                        // Underflow sets the flag even if a read clears it this cycle.
                        flag <= 1'b1;
                        if (reload) begin
                            count <= latch;
                        end else begin
                            count <= 8'hFF;
                            fast  <= 1'b1;
                        end
                    end else begin
                        count <= count - 8'h01;
                    end
                end else begin
                    presc_cnt <= presc_cnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/riot_multi.sv
// RIOT-style peripheral: byte RAM, NPORTS I/O ports with DDR, NTIMERS timers, pin-7 edge detect.
// Read data registered on the edge of the access cycle (one ce of latency), held until next read.
// No backpressure; an access is any cycle with ce & cs, other cycles change nothing.
// Ports: clk, reset (sync, active high), ce, cs, rs (1 = RAM), we, addr, d_in, d_out,
//        irq_n (combinational), port_in / port_out / port_dir (8 bits per port).
module riot_multi
    import riot_pkg::*;
#(
    parameter int RAM_AW   = 7,
    parameter int NPORTS   = 2,
    parameter int NTIMERS  = 1,
    parameter int RAM_INIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  cs,
    input  logic                  rs,
    input  logic                  we,
    input  logic [7:0]            addr,
    input  logic [7:0]            d_in,
    output logic [7:0]            d_out,
    output logic                  irq_n,
    input  logic [8*NPORTS-1:0]   port_in,
    output logic [8*NPORTS-1:0]   port_out,
    output logic [8*NPORTS-1:0]   port_dir
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [7:0] ram [RAM_DEPTH];
    logic [7:0] pout [NPORTS];
    logic [7:0] pdir [NPORTS];

    logic [NPORTS-1:0] e_flag, e_en, e_pol, e_prev, eff, e_evt;
    // Blocks a fake edge on the first sample after reset.
    logic              e_prev_vld;

    logic [NTIMERS-1:0] t_flag, t_en, t_wr, t_rd;
    logic [7:0]         t_count [NTIMERS];

    logic              acc, reg_acc, flag_rd;
    logic [1:0]        area, pidx;
    logic [RAM_AW-1:0] ram_a;
    logic [7:0]        flag_byte, rd_data;

    assign acc     = ce & cs;
    assign reg_acc = acc & ~rs;
    assign area    = addr[7:6];
    assign ram_a   = addr[RAM_AW-1:0];
    // Port index wraps modulo the number of ports actually built.
    assign pidx    = 2'(32'(addr[2:1]) % NPORTS);
    assign flag_rd = reg_acc & ~we & (area == AREA_TIMER) & addr[0];

    always_comb begin
        port_out = '0;
        port_dir = '0;
        eff      = '0;
        e_evt    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            port_out[8*p +: 8] = pout[p];
            port_dir[8*p +: 8] = pdir[p];
            eff[p]   = pdir[p][7] ? pout[p][7] : port_in[8*p+7];
            e_evt[p] = e_prev_vld & (e_pol[p] ? (~e_prev[p] & eff[p])
                                              : (e_prev[p] & ~eff[p]));
        end
    end

    always_comb begin
        t_wr = '0;
        t_rd = '0;
        for (int t = 0; t < NTIMERS; t++) begin
            t_wr[t] = reg_acc & we & (area == AREA_TIMER) & (addr[5:4] == 2'(t));
            t_rd[t] = reg_acc & ~we & (area == AREA_TIMER) & ~addr[0] & (addr[5:4] == 2'(t));
        end
    end

    for (genvar t = 0; t < NTIMERS; t++) begin : g_timer
        riot_timer u_timer (
            .clk        (clk),
            .reset      (reset),
            .ce         (ce),
            .wr         (t_wr[t]),
            .rd         (t_rd[t]),
            .cfg_irq_en (addr[3]),
            .cfg_reload (addr[2]),
            .cfg_presc  (presc_e'(addr[1:0])),
            .d_in       (d_in),
            .count      (t_count[t]),
            .flag       (t_flag[t]),
            .irq_en     (t_en[t])
        );
    end

    always_comb begin
        flag_byte = 8'h00;
        for (int t = 0; t < NTIMERS; t++) begin
            flag_byte[t] = t_flag[t];
        end
        for (int p = 0; p < NPORTS; p++) begin
            flag_byte[4+p] = e_flag[p];
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (rs) begin
            rd_data = ram[ram_a];
        end else begin
            case (area)
                AREA_PORT: begin
                    for (int p = 0; p < NPORTS; p++) begin
                        if (pidx == 2'(p)) begin
                            rd_data = addr[0] ? pdir[p]
                                              : ((pout[p] & pdir[p]) | (port_in[8*p +: 8] & ~pdir[p]));
                        end
                    end
                end
                AREA_TIMER: begin
                    if (addr[0]) begin
                        rd_data = flag_byte;
                    end else begin
                        for (int t = 0; t < NTIMERS; t++) begin
                            if (addr[5:4] == 2'(t)) begin
                                rd_data = t_count[t];
                            end
                        end
                    end
                end
                AREA_EDGE: rd_data = 8'h00;
                AREA_NONE: rd_data = 8'h00;
                default:   rd_data = 8'h00;
            endcase
        end
    end

    assign irq_n = ~((|(t_flag & t_en)) | (|(e_flag & e_en)));

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out      <= 8'hFF;
            e_flag     <= '0;
            e_en       <= '0;
            e_pol      <= '0;
            e_prev     <= '0;
            e_prev_vld <= 1'b0;
            for (int p = 0; p < NPORTS; p++) begin
                pout[p] <= 8'h00;
                pdir[p] <= 8'h00;
            end
        end else if (ce) begin
            e_prev     <= eff;
            e_prev_vld <= 1'b1;
            // A fresh edge survives a flag read in the same cycle.
            e_flag     <= (flag_rd ? '0 : e_flag) | e_evt;
            if (cs) begin
                if (!we) begin
                    d_out <= rd_data;
                end else if (!rs) begin
                    if (area == AREA_PORT) begin
                        for (int p = 0; p < NPORTS; p++) begin
                            if (pidx == 2'(p)) begin
                                if (addr[0]) pdir[p] <= d_in;
                                else         pout[p] <= d_in;
                            end
                        end
                    end else if (area == AREA_EDGE) begin
                        for (int p = 0; p < NPORTS; p++) begin
                            if (addr[1:0] == 2'(p)) begin
                                e_pol[p] <= d_in[0];
                                e_en[p]  <= d_in[1];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram[i] <= (RAM_INIT != 0) ? RAM_INIT_IMAGE[i % RAM_IMAGE_BYTES] : 8'h00;
            end
        end else if (acc && rs && we) begin
            ram[ram_a] <= d_in;
        end
    end

endmodule

// File: tb/tb_riot_multi.sv
// Directed bench for riot_multi: RAM aliasing, ports, timers, edge detect, reset.
// Reads push their expected d_out into a scoreboard; a monitor pops after each read edge.
// Level outputs (irq_n, port pins, reset values) are compared inline.
module tb_riot_multi;

    logic        clk = 1'b0;
    logic        reset, ce, cs, rs, we;
    logic [7:0]  addr, d_in, d_out;
    logic        irq_n;
    logic [15:0] port_in, port_out, port_dir;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];
    int         id_q  [$];
    int         next_id = 0;

    riot_multi #(
        .RAM_AW   (7),
        .NPORTS   (2),
        .NTIMERS  (1),
        .RAM_INIT (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .cs       (cs),
        .rs       (rs),
        .we       (we),
        .addr     (addr),
        .d_in     (d_in),
        .d_out    (d_out),
        .irq_n    (irq_n),
        .port_in  (port_in),
        .port_out (port_out),
        .port_dir (port_dir)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every real read access is followed by a compare of d_out.
    always @(posedge clk) begin
        if (!reset && ce && cs && !we) begin
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underrun: read with no expectation, d_out=%02h", d_out);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                automatic int         id = id_q.pop_front();
                if (d_out !== e) begin
                    n_err++;
                    $display("FAIL read#%0d: d_out=%02h expected %02h", id, d_out, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        cs = 1'b1; rs = r; we = w; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; rs = 1'b0; we = 1'b0; addr = 8'h00; d_in = 8'h00;
    endtask

    task automatic wr(input logic r, input logic [7:0] a, input logic [7:0] d);
        bus(r, 1'b1, a, d);
    endtask

    task automatic rd(input logic r, input logic [7:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        id_q.push_back(next_id);
        next_id++;
        bus(r, 1'b0, a, 8'h00);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; cs = 1'b0; rs = 1'b0; we = 1'b0;
        addr = 8'h00; d_in = 8'h00; port_in = 16'h0000;
        idle(3);
        chk("rst_d_out", 16'(d_out), 16'h00FF);
        chk("rst_irq_n", 16'(irq_n), 16'h0001);
        chk("rst_port_out", port_out, 16'h0000);
        chk("rst_port_dir", port_dir, 16'h0000);
        reset = 1'b0;

        rd(1'b0, 8'h40, 8'h00);          // timer 0 count after reset
        rd(1'b0, 8'h41, 8'h00);          // no flags after reset

        // RAM: 7-bit address, 0xFF aliases 0x7F
        wr(1'b1, 8'h7F, 8'h5A);
        rd(1'b1, 8'hFF, 8'h5A);
        rd(1'b1, 8'h00, 8'h00);

        // ce low: neither read nor write takes effect
        ce = 1'b0;
        bus(1'b1, 1'b0, 8'h7F, 8'h00);
        bus(1'b1, 1'b1, 8'h10, 8'h77);
        chk("ce_hold_d_out", 16'(d_out), 16'h0000);
        ce = 1'b1;
        rd(1'b1, 8'h10, 8'h00);

        // Unused register space
        wr(1'b0, 8'hC0, 8'hFF);
        rd(1'b1, 8'h7F, 8'h5A);
        rd(1'b0, 8'hC0, 8'h00);

        // One-shot, prescale 8, irq enabled, count 3: underflow 32 ce later
        wr(1'b0, 8'h49, 8'h03);
        idle(31);
        chk("os_irq_before", 16'(irq_n), 16'h0001);
        idle(1);
        chk("os_irq_at_32", 16'(irq_n), 16'h0000);
        rd(1'b0, 8'h48, 8'hFF);
        rd(1'b0, 8'h48, 8'hFE);
        rd(1'b0, 8'h41, 8'h00);          // count read cleared the flag
        chk("os_irq_cleared", 16'(irq_n), 16'h0001);
        idle(300);
        rd(1'b0, 8'h48, 8'h00);          // parked at zero
        rd(1'b0, 8'h41, 8'h00);          // no second underflow

        // Write landing on the underflow cycle wins
        wr(1'b0, 8'h49, 8'h03);
        idle(31);
        wr(1'b0, 8'h49, 8'h44);
        chk("coll_irq_n", 16'(irq_n), 16'h0001);
        rd(1'b0, 8'h41, 8'h00);
        rd(1'b0, 8'h48, 8'h44);

        // Prescale 1 from zero: flag next ce, then reset drops irq
        wr(1'b0, 8'h48, 8'h00);
        idle(1);
        chk("ps1_irq_n", 16'(irq_n), 16'h0000);
        pulse_reset();
        chk("rst2_d_out", 16'(d_out), 16'h00FF);
        chk("rst2_irq_n", 16'(irq_n), 16'h0001);

        // Reset in the middle of a count aborts it
        wr(1'b0, 8'h49, 8'h10);
        idle(20);
        pulse_reset();
        idle(200);
        chk("abort_irq_n", 16'(irq_n), 16'h0001);
        rd(1'b0, 8'h41, 8'h00);
        rd(1'b0, 8'h40, 8'h00);

        // Reload mode, prescale 8, count 3: flag every 32 ce
        pulse_reset();
        wr(1'b0, 8'h4D, 8'h03);
        idle(31);
        chk("rl_irq_before", 16'(irq_n), 16'h0001);
        idle(1);
        chk("rl_irq_at_32", 16'(irq_n), 16'h0000);
        rd(1'b0, 8'h41, 8'h01);
        rd(1'b0, 8'h48, 8'h03);
        chk("rl_irq_cleared", 16'(irq_n), 16'h0001);
        idle(29);
        chk("rl_irq_before2", 16'(irq_n), 16'h0001);
        idle(1);
        chk("rl_irq_at_64", 16'(irq_n), 16'h0000);
        rd(1'b0, 8'h48, 8'h03);

        // Ports
        pulse_reset();
        wr(1'b0, 8'h01, 8'hF0);
        wr(1'b0, 8'h00, 8'hA5);
        port_in = 16'h5A3C;
        rd(1'b0, 8'h00, 8'hAC);
        chk("port_out_hi", 16'(port_out[7:4]), 16'h000A);
        chk("port_dir", port_dir, 16'h00F0);
        rd(1'b0, 8'h05, 8'hF0);          // port index 2 wraps to port 0
        rd(1'b0, 8'h02, 8'h5A);          // port 1 all inputs

        // Edge detect on port 1 pin 7, rising, irq enabled
        wr(1'b0, 8'h81, 8'h03);
        idle(2);
        rd(1'b0, 8'h41, 8'h00);
        port_in[15] = 1'b1;
        idle(1);
        chk("edge_irq_n", 16'(irq_n), 16'h0000);
        rd(1'b0, 8'h41, 8'h20);
        chk("edge_irq_cleared", 16'(irq_n), 16'h0001);
        rd(1'b0, 8'h41, 8'h00);

        // Edge arriving on the same cycle as a flag read stays set
        port_in[15] = 1'b0;
        idle(2);
        port_in[15] = 1'b1;
        rd(1'b0, 8'h41, 8'h00);
        chk("edge_coinc_irq_n", 16'(irq_n), 16'h0000);
        rd(1'b0, 8'h41, 8'h20);

        idle(2);
        chk("sb_drain", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
